wave_capture_mc: RTL

- Multi-channel, parametrised successor to the single-channel wave capture path.
- Captures NUM_CH audio channels into one shared, double-buffered sample RAM after a selectable trigger.
- Presents one 8-bit-style display sample per write, and flips the buffer half when the display is idle.
- Sits between the codec sample stream and ram_1w2r, and feeds read_index to the wave display.

---
 rtl/wave_pkg.sv | 23 ++
 rtl/wave_trigger_detect.sv | 69 ++++++
 rtl/wave_capture_mc.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/wave_pkg.sv
// Shared definitions for the multi-channel wave capture path: trigger modes, capture states
// and the signed-to-offset-binary display conversion. Optional feature macro: WAVE_CAPTURE_HOLDOFF_EN.
package wave_pkg;

  localparam logic [1:0] TRIG_FREE = 2'b00;
  localparam logic [1:0] TRIG_RISE = 2'b01;
  localparam logic [1:0] TRIG_FALL = 2'b10;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } cap_state_t;

  // Samples are handed over left-justified in this width, so IN_WIDTH may be at most 32.
  localparam int SAMP_MAX_W = 32;

  // Offset-binary flip of a left-justified signed sample; the caller keeps the top OUT_WIDTH bits.
  function automatic logic [SAMP_MAX_W-1:0] to_display(input logic [SAMP_MAX_W-1:0] s_lj);
    return {~s_lj[SAMP_MAX_W-1], s_lj[SAMP_MAX_W-2:0]};
  endfunction

endpackage

// File: rtl/wave_trigger_detect.sv
// Trigger channel mux, previous-sample register and zero-crossing compare.
// With WAVE_CAPTURE_HOLDOFF_EN defined, a post-flip holdoff counter masks the trigger.
module wave_trigger_detect
  import wave_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CH_W     = 1,
  parameter int IN_WIDTH = 16
`ifdef WAVE_CAPTURE_HOLDOFF_EN
  ,
  parameter int HOLDOFF  = 4
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*IN_WIDTH-1:0] sample_vec,
  input  logic [CH_W-1:0]            trig_sel,
  input  logic [1:0]                 trig_mode,
  input  logic                       accept,
`ifdef WAVE_CAPTURE_HOLDOFF_EN
  input  logic                       armed,
  input  logic                       flip,
`endif
  output logic                       trig_hit
);

  logic signed [IN_WIDTH-1:0] cur_sample;
  logic signed [IN_WIDTH-1:0] prev_p0;
  logic                       crossing;

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    cur_sample = sample_vec[IN_WIDTH-1:0];
    for (int c = 1; c < NUM_CH; c++) begin
      if (trig_sel == CH_W'(c)) cur_sample = sample_vec[c*IN_WIDTH +: IN_WIDTH];
    end
  end

  always_comb begin
    case (trig_mode)
      TRIG_RISE: crossing = prev_p0[IN_WIDTH-1] && !cur_sample[IN_WIDTH-1];
      TRIG_FALL: crossing = !prev_p0[IN_WIDTH-1] && cur_sample[IN_WIDTH-1];
      default:   crossing = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_p0 <= '0;
    else if (accept) prev_p0 <= cur_sample;
  end

`ifdef WAVE_CAPTURE_HOLDOFF_EN
  localparam int HO_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  logic [HO_W-1:0] hold_cnt;

  // Loaded on every buffer flip, counts down on strobes seen while armed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_cnt <= '0;
    else if (flip) hold_cnt <= HO_W'(HOLDOFF);
    else if (accept && armed && (hold_cnt != '0)) hold_cnt <= hold_cnt - 1'b1;
  end

  assign trig_hit = crossing && (hold_cnt == '0);
`else
  assign trig_hit = crossing;
`endif

endmodule

// File: rtl/wave_capture_mc.sv
// Multi-channel double-buffered wave capture: trigger FSM, per-channel write sequencer and
// RAM address formation. Optional post-flip trigger holdoff via WAVE_CAPTURE_HOLDOFF_EN.
module wave_capture_mc
  import wave_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int CH_W      = 1,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int ADDR_W    = 8,
  parameter int HOLDOFF   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       new_sample_ready,
  input  logic [NUM_CH*IN_WIDTH-1:0] new_sample_in,
  input  logic [CH_W-1:0]            trig_sel,
  input  logic [1:0]                 trig_mode,
  input  logic                       wave_display_idle,
  output logic                       write_enable,
  output logic [CH_W+ADDR_W:0]       write_address,
  output logic [OUT_WIDTH-1:0]       write_sample,
  output logic                       read_index,
  output logic                       overrun
);

  localparam logic [ADDR_W-1:0] IDX_MAX = '1;
  localparam logic [CH_W-1:0]   CH_LAST = CH_W'(NUM_CH - 1);

  cap_state_t state, state_nxt;

  logic                          accept;
  logic                          start_wr;
  logic                          step_last;
  logic                          flip;
  logic                          trig_hit;
  logic                          seq_busy;
  logic                          last_buf_p0;
  logic [ADDR_W-1:0]             cap_idx;
  logic [ADDR_W-1:0]             wr_idx_p1;
  logic [CH_W-1:0]               wr_ch_p1;
  logic [CH_W-1:0]               ch_next;
  logic [CH_W-1:0]               sel_ch;
  logic                          wr_half_p1;
  logic [NUM_CH*OUT_WIDTH-1:0]   disp_now;
  logic [NUM_CH*OUT_WIDTH-1:0]   disp_vec_p0;
  logic [NUM_CH*OUT_WIDTH-1:0]   sel_vec;
  logic [OUT_WIDTH-1:0]          sel_sample;

  function automatic logic [OUT_WIDTH-1:0] to_display_w(input logic signed [IN_WIDTH-1:0] s);
    logic [SAMP_MAX_W-1:0] lj;
    logic [SAMP_MAX_W-1:0] d;
    lj = SAMP_MAX_W'(s) << (SAMP_MAX_W - IN_WIDTH);
    d  = to_display(lj);
    return d[SAMP_MAX_W-1 -: OUT_WIDTH];
  endfunction

`ifndef WAVE_CAPTURE_HOLDOFF_EN
  localparam int unused_holdoff = HOLDOFF;
`endif

  wave_trigger_detect #(
    .NUM_CH   (NUM_CH),
    .CH_W     (CH_W),
    .IN_WIDTH (IN_WIDTH)
`ifdef WAVE_CAPTURE_HOLDOFF_EN
    ,
    .HOLDOFF  (HOLDOFF)
`endif
  ) u_trig (
    .clk        (clk),
    .reset      (reset),
    .sample_vec (new_sample_in),
    .trig_sel   (trig_sel),
    .trig_mode  (trig_mode),
    .accept     (accept),
`ifdef WAVE_CAPTURE_HOLDOFF_EN
    .armed      (state == ARMED),
    .flip       (flip),
`endif
    .trig_hit   (trig_hit)
  );

  // A strobe is only taken while no channel writes are still pending.
  assign accept    = new_sample_ready && !seq_busy;
  assign step_last = seq_busy && (wr_ch_p1 == CH_LAST - 1'b1);

  always_comb begin
    disp_now = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      disp_now[c*OUT_WIDTH +: OUT_WIDTH] = to_display_w(new_sample_in[c*IN_WIDTH +: IN_WIDTH]);
    end
  end

  always_comb begin
    state_nxt = state;
    start_wr  = 1'b0;
    flip      = 1'b0;
    case (state)
      ARMED: begin
        if (accept && trig_hit) begin
          start_wr  = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (accept) begin
          start_wr = 1'b1;
          if ((NUM_CH == 1) && (cap_idx == IDX_MAX)) state_nxt = WAIT;
        end
        if (step_last && last_buf_p0) state_nxt = WAIT;
      end
      WAIT: begin
        if (wave_display_idle && !seq_busy) begin
          flip      = 1'b1;
          state_nxt = ARMED;
        end
      end
      default: state_nxt = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARMED;
    else state <= state_nxt;
  end

  // Channel 0 goes out straight from the input; later channels from the latched vector.
  assign ch_next    = wr_ch_p1 + 1'b1;
  assign sel_vec    = start_wr ? disp_now : disp_vec_p0;
  assign sel_ch     = start_wr ? '0 : ch_next;
  assign sel_sample = sel_vec[sel_ch*OUT_WIDTH +: OUT_WIDTH];

  // Stage p0: converted samples of the accepted strobe
  always_ff @(posedge clk) begin
    if (start_wr) disp_vec_p0 <= disp_now;
  end

  // Stage p1: one RAM write per cycle, channel 0 first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enable <= 1'b0;
      write_sample <= '0;
      wr_ch_p1     <= '0;
      wr_idx_p1    <= '0;
      wr_half_p1   <= 1'b0;
      cap_idx      <= '0;
      seq_busy     <= 1'b0;
      last_buf_p0  <= 1'b0;
      read_index   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (start_wr) begin
        write_enable <= 1'b1;
        write_sample <= sel_sample;
        wr_ch_p1     <= '0;
        wr_idx_p1    <= cap_idx;
        wr_half_p1   <= ~read_index;
        cap_idx      <= cap_idx + 1'b1;
        last_buf_p0  <= (cap_idx == IDX_MAX);
        seq_busy     <= (NUM_CH > 1);
      end else if (seq_busy) begin
        write_enable <= 1'b1;
        write_sample <= sel_sample;
        wr_ch_p1     <= ch_next;
        if (step_last) seq_busy <= 1'b0;
      end else begin
        write_enable <= 1'b0;
      end
      if (new_sample_ready && seq_busy) overrun <= 1'b1;
      if (flip) read_index <= ~read_index;
    end
  end

  assign write_address = {wr_half_p1, wr_ch_p1, wr_idx_p1};

endmodule
